dmem_responder: RTL

- Multi-cycle data-memory responder; the target end of the pipelined CPU's load/store request interface.
- Replaces the single-cycle data memory so that the MEM stage sees realistic latency.
- Accepts word read and write requests through a valid/ready handshake and returns one response per request after a fixed LATENCY.
- Drives a stall indication that the CPU hazard logic uses to freeze the pipeline.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_delay_line.sv | 43 ++++
 rtl/dmem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared sizing and types for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int DEPTH_LOG2  = 10;
  localparam int LATENCY_MAX = 8;
  localparam int CNT_W       = $clog2(LATENCY_MAX);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_delay_line.sv
// Fixed-depth shift register carrying {valid, request} so that each accepted
// request emerges exactly DEPTH edges later; used by the pipelined responder.
module dmem_delay_line
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      valid_i,
  input  dmem_req_t req_i,
  output logic      valid_o,
  output dmem_req_t req_o
);

  logic      valid_q [DEPTH];
  dmem_req_t req_q   [DEPTH];

  // Only the valid bits need clearing; payload is ignored when invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    req_q[0] <= req_i;
    for (int i = 1; i < DEPTH; i++) begin
      req_q[i] <= req_q[i-1];
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign req_o   = req_q[DEPTH-1];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage.
// Define DMEM_PIPELINE_EN for up to LATENCY requests in flight; default is single-outstanding.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_wr,
  output logic              stall
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic              rsp_valid_q;
  logic              rsp_wr_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  dmem_req_t req_d;
  logic      accept;
  logic      commitEn;
  dmem_req_t commitReq;
  logic      unusedAddrBits;

  // Upper address bits alias silently; bit 0 is the byte lane of a word.
  assign req_d          = '{wr: req_wr, idx: req_addr[DEPTH_LOG2:1], wdata: req_wdata};
  assign unusedAddrBits = ^{req_addr[ADDR_W-1:DEPTH_LOG2+1], req_addr[0]};
  assign accept         = req_valid & req_ready;

`ifdef DMEM_PIPELINE_EN

  logic      dlValid;
  dmem_req_t dlReq;

  dmem_delay_line #(
    .DEPTH (LATENCY)
  ) u_delay (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (accept),
    .req_i   (req_d),
    .valid_o (dlValid),
    .req_o   (dlReq)
  );

  assign commitEn  = dlValid & ~rst;
  assign commitReq = dlReq;
  assign req_ready = ~rst;
  assign stall     = 1'b0;

`else

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  dmem_req_t       req_q;

  // RESP is also an accepting state so back-to-back requests lose no cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            state_q <= BUSY;
            cnt_q   <= CNT_W'(LATENCY - 1);
            req_q   <= req_d;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign commitEn  = (state_q == BUSY) && (cnt_q == '0) && !rst;
  assign commitReq = req_q;
  assign req_ready = ~rst & (state_q != BUSY);
  assign stall     = ~req_ready;

`endif

  // Storage survives reset; a store lands only at its response edge.
  always_ff @(posedge clk) begin
    if (commitEn && commitReq.wr) begin
      mem_q[commitReq.idx] <= commitReq.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= commitEn;
      if (commitEn) begin
        rsp_wr_q    <= commitReq.wr;
        rsp_rdata_q <= commitReq.wr ? '0 : mem_q[commitReq.idx];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
